// File: rtl/game_pkg.sv
// Constants and types shared by the game logic and the display side of the game.
package game_pkg;

  localparam int unsigned SCREEN_W        = 800;
  localparam int unsigned SCREEN_H        = 600;
  localparam int unsigned PLAYFIELD_MIN   = 8;
  localparam int unsigned PLAYFIELD_MAX   = 792;
  localparam int unsigned BALL_SIZE_PIXEL = 8;
  localparam int unsigned PADDLE_Y_PIXEL  = 584;

  localparam int unsigned PADDLE_RESET_X  = 370;
  localparam int unsigned BALL_RESET_X    = 395;
  localparam int unsigned BALL_RESET_Y    = 400;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned V_CNT_W = 10;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_BLACK = 3'b000;
  localparam rgb_t RGB_WHITE = 3'b111;
  localparam rgb_t RGB_CYAN  = 3'b011;
  localparam rgb_t RGB_RED   = 3'b100;

  // Object positions as delivered by the game logic, held for one whole frame.
  typedef struct packed {
    logic [POS_W-1:0] paddle_x;
    logic [POS_W-1:0] ball_x;
    logic [POS_W-1:0] ball_y;
  } pos_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus combinational decode of sync, visible area and per-frame event points.
module vga_timing
  import game_pkg::*;
#(
  parameter int unsigned H_VISIBLE = SCREEN_W,
  parameter int unsigned H_FRONT   = 56,
  parameter int unsigned H_SYNC    = 120,
  parameter int unsigned H_BACK    = 64,
  parameter int unsigned V_VISIBLE = SCREEN_H,
  parameter int unsigned V_FRONT   = 37,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BACK    = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [CNT_W-1:0]   h_cnt_q,
  output logic [V_CNT_W-1:0] v_cnt_q,
  output logic               hsync_c,
  output logic               vsync_c,
  output logic               visible_c,
  output logic               start_c,
  output logic               capture_c
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [CNT_W-1:0]   h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_d;

  // Line counter wraps every H_TOTAL pixels and carries into the frame counter.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_CNT_W'(V_TOTAL - 1)) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + V_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hsync_c   = (h_cnt_q >= CNT_W'(H_SYNC_START)) && (h_cnt_q < CNT_W'(H_SYNC_END));
  assign vsync_c   = (v_cnt_q >= V_CNT_W'(V_SYNC_START)) && (v_cnt_q < V_CNT_W'(V_SYNC_END));
  assign visible_c = (h_cnt_q < CNT_W'(H_VISIBLE)) && (v_cnt_q < V_CNT_W'(V_VISIBLE));
  assign start_c   = (h_cnt_q == '0) && (v_cnt_q == V_CNT_W'(V_VISIBLE));
  assign capture_c = (h_cnt_q == '0) && (v_cnt_q == V_CNT_W'(V_TOTAL - 1));

endmodule

// File: rtl/frame_renderer.sv
// VGA renderer for ball and paddle with per-frame position snapshot and START_UPDATE pulse.
// Optional playfield border is built only when RENDER_BORDER_EN is defined.
module frame_renderer
  import game_pkg::*;
#(
  parameter int unsigned H_VISIBLE           = SCREEN_W,
  parameter int unsigned H_FRONT             = 56,
  parameter int unsigned H_SYNC              = 120,
  parameter int unsigned H_BACK              = 64,
  parameter int unsigned V_VISIBLE           = SCREEN_H,
  parameter int unsigned V_FRONT             = 37,
  parameter int unsigned V_SYNC              = 6,
  parameter int unsigned V_BACK              = 23,
  parameter int unsigned PADDLE_LENGTH_PIXEL = 60,
  parameter int unsigned PADDLE_HEIGHT_PIXEL = 8,
  parameter int unsigned PADDLE_TOP          = PADDLE_Y_PIXEL
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [POS_W-1:0] PADDLE_X_PIXEL,
  input  logic [POS_W-1:0] BALL_X_PIXEL,
  input  logic [POS_W-1:0] BALL_Y_PIXEL,
  output logic             START_UPDATE,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             RED,
  output logic             GREEN,
  output logic             BLUE
);

  logic [CNT_W-1:0]   h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0]   v_ext;
  logic               hsync_c;
  logic               vsync_c;
  logic               visible_c;
  logic               start_c;
  logic               capture_c;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .h_cnt_q   (h_cnt),
    .v_cnt_q   (v_cnt),
    .hsync_c   (hsync_c),
    .vsync_c   (vsync_c),
    .visible_c (visible_c),
    .start_c   (start_c),
    .capture_c (capture_c)
  );

  assign v_ext = {1'b0, v_cnt};

  pos_t snap_q;
  pos_t snap_d;

  // Positions are taken on the last line only, so a drawn frame never mixes two updates.
  always_comb begin
    snap_d = snap_q;
    if (capture_c) begin
      snap_d.paddle_x = PADDLE_X_PIXEL;
      snap_d.ball_x   = BALL_X_PIXEL;
      snap_d.ball_y   = BALL_Y_PIXEL;
    end
  end

  logic [CNT_W-1:0] ball_x0;
  logic [CNT_W-1:0] ball_x1;
  logic [CNT_W-1:0] ball_y0;
  logic [CNT_W-1:0] ball_y1;
  logic [CNT_W-1:0] pad_x0;
  logic [CNT_W-1:0] pad_x1;
  logic             ball_c;
  logic             paddle_c;

  // 11-bit edges so objects near the right/bottom clip instead of wrapping to the left/top.
  assign ball_x0 = {1'b0, snap_q.ball_x};
  assign ball_y0 = {1'b0, snap_q.ball_y};
  assign pad_x0  = {1'b0, snap_q.paddle_x};
  assign ball_x1 = ball_x0 + CNT_W'(BALL_SIZE_PIXEL);
  assign ball_y1 = ball_y0 + CNT_W'(BALL_SIZE_PIXEL);
  assign pad_x1  = pad_x0 + CNT_W'(PADDLE_LENGTH_PIXEL);

  assign ball_c   = (h_cnt >= ball_x0) && (h_cnt < ball_x1) &&
                    (v_ext >= ball_y0) && (v_ext < ball_y1);
  assign paddle_c = (h_cnt >= pad_x0) && (h_cnt < pad_x1) &&
                    (v_ext >= CNT_W'(PADDLE_TOP)) &&
                    (v_ext < CNT_W'(PADDLE_TOP + PADDLE_HEIGHT_PIXEL));

`ifdef RENDER_BORDER_EN
  logic border_c;
  assign border_c = (h_cnt < CNT_W'(PLAYFIELD_MIN)) || (h_cnt >= CNT_W'(PLAYFIELD_MAX)) ||
                    (v_ext < CNT_W'(PLAYFIELD_MIN));
`endif

  rgb_t rgb_d;
  rgb_t rgb_q;

  // Priority: ball over paddle over border over background.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (visible_c) begin
      if (ball_c) begin
        rgb_d = RGB_WHITE;
      end else if (paddle_c) begin
        rgb_d = RGB_CYAN;
`ifdef RENDER_BORDER_EN
      end else if (border_c) begin
        rgb_d = RGB_RED;
`endif
      end
    end
  end

  logic hsync_q;
  logic vsync_q;
  logic start_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hsync_q         <= 1'b0;
      vsync_q         <= 1'b0;
      start_q         <= 1'b0;
      rgb_q           <= RGB_BLACK;
      snap_q.paddle_x <= POS_W'(PADDLE_RESET_X);
      snap_q.ball_x   <= POS_W'(BALL_RESET_X);
      snap_q.ball_y   <= POS_W'(BALL_RESET_Y);
    end else begin
      hsync_q <= hsync_c;
      vsync_q <= vsync_c;
      start_q <= start_c;
      rgb_q   <= rgb_d;
      snap_q  <= snap_d;
    end
  end

  assign START_UPDATE = start_q;
  assign HSYNC        = hsync_q;
  assign VSYNC        = vsync_q;
  assign RED          = rgb_q[2];
  assign GREEN        = rgb_q[1];
  assign BLUE         = rgb_q[0];

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench: a shrunken-timing instance for full frames plus a default-timing instance.
module tb_frame_renderer;

  localparam int S_HV = 64, S_HF = 8, S_HS = 12, S_HB = 6;
  localparam int S_VV = 48, S_VF = 4, S_VS = 2,  S_VB = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int S_PL = 16, S_PH = 8, S_PY = 40;

  localparam int D_HV = 800, D_HF = 56, D_HS = 120, D_HB = 64;
  localparam int D_VV = 600, D_VF = 37, D_VS = 6,   D_VB = 23;
  localparam int D_HT = D_HV + D_HF + D_HS + D_HB;
  localparam int D_VT = D_VV + D_VF + D_VS + D_VB;

  bit         clk;
  logic       rst_n;
  logic [9:0] paddle_x, ball_x, ball_y;

  logic s_su, s_hs, s_vs, s_r, s_g, s_b;
  logic d_su, d_hs, d_vs, d_r, d_g, d_b;

  frame_renderer #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .PADDLE_LENGTH_PIXEL(S_PL), .PADDLE_HEIGHT_PIXEL(S_PH), .PADDLE_TOP(S_PY)
  ) u_small (
    .CLK(clk), .RESET_N(rst_n),
    .PADDLE_X_PIXEL(paddle_x), .BALL_X_PIXEL(ball_x), .BALL_Y_PIXEL(ball_y),
    .START_UPDATE(s_su), .HSYNC(s_hs), .VSYNC(s_vs),
    .RED(s_r), .GREEN(s_g), .BLUE(s_b)
  );

  frame_renderer u_dflt (
    .CLK(clk), .RESET_N(rst_n),
    .PADDLE_X_PIXEL(paddle_x), .BALL_X_PIXEL(ball_x), .BALL_Y_PIXEL(ball_y),
    .START_UPDATE(d_su), .HSYNC(d_hs), .VSYNC(d_vs),
    .RED(d_r), .GREEN(d_g), .BLUE(d_b)
  );

  always #5 clk = ~clk;

  // Expected {START_UPDATE,HSYNC,VSYNC,R,G,B} produced from raster position (h,v) and held positions.
  function automatic logic [5:0] model(int h, int v, int hv, int hf, int hsn, int vv, int vf,
                                       int vsn, int bx, int by, int px, int py, int pl, int ph);
    logic       su, hs, vs;
    logic [2:0] c;
    su = (h == 0) && (v == vv);
    hs = (h >= hv + hf) && (h < hv + hf + hsn);
    vs = (v >= vv + vf) && (v < vv + vf + vsn);
    c  = 3'b000;
    if (h < hv && v < vv) begin
      if (h >= bx && h < bx + 8 && v >= by && v < by + 8) c = 3'b111;
      else if (h >= px && h < px + pl && v >= py && v < py + ph) c = 3'b011;
`ifdef RENDER_BORDER_EN
      else if (h < 8 || h >= 792 || v < 8) c = 3'b100;
`endif
    end
    return {su, hs, vs, c};
  endfunction

  logic [5:0] qs[$];
  logic [5:0] qd[$];
  int ks, kd;
  int snap_s[3];
  int snap_d[3];

  // Predictor: one expected output per clock edge for each instance.
  always @(posedge clk) begin
    int h, v;
    if (!rst_n) begin
      ks = 0; kd = 0;
      snap_s = '{370, 395, 400};
      snap_d = '{370, 395, 400};
      qs.push_back(6'b0);
      qd.push_back(6'b0);
    end else begin
      h = ks % S_HT; v = (ks / S_HT) % S_VT;
      qs.push_back(model(h, v, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS,
                         snap_s[1], snap_s[2], snap_s[0], S_PY, S_PL, S_PH));
      if (h == 0 && v == S_VT - 1) snap_s = '{int'(paddle_x), int'(ball_x), int'(ball_y)};
      ks++;
      h = kd % D_HT; v = (kd / D_HT) % D_VT;
      qd.push_back(model(h, v, D_HV, D_HF, D_HS, D_VV, D_VF, D_VS,
                         snap_d[1], snap_d[2], snap_d[0], 584, 60, 8));
      if (h == 0 && v == D_VT - 1) snap_d = '{int'(paddle_x), int'(ball_x), int'(ball_y)};
      kd++;
    end
  end

  int n_checks, n_fail;
  int cyc, since_rel, last_pulse, intervals;
  bit last_valid, rise_s_done, rise_d_done, hs_s_prev, hs_d_prev;
  int rst_req, rst_seen;
  logic [5:0] rst_snap_s, rst_snap_d;
  bit done_req, done_seen;

  task automatic check_bits(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard every cycle and runs the timing-interval checks.
  always @(negedge clk) begin
    cyc++;
    if (qs.size() > 0) check_bits("small_out", {s_su, s_hs, s_vs, s_r, s_g, s_b}, qs.pop_front());
    if (qd.size() > 0) check_bits("dflt_out", {d_su, d_hs, d_vs, d_r, d_g, d_b}, qd.pop_front());
    if (!rst_n) begin
      since_rel = 0; rise_s_done = 0; rise_d_done = 0; last_valid = 0;
    end else begin
      since_rel++;
      if (d_hs && !hs_d_prev && !rise_d_done) begin
        check_int("hsync_first_rise_dflt", since_rel, D_HV + D_HF + 1);
        rise_d_done = 1;
      end
      if (s_hs && !hs_s_prev && !rise_s_done) begin
        check_int("hsync_first_rise_small", since_rel, S_HV + S_HF + 1);
        rise_s_done = 1;
      end
      if (s_su) begin
        if (last_valid) begin
          check_int("start_update_period", cyc - last_pulse, S_FRAME);
          intervals++;
        end
        last_pulse = cyc;
        last_valid = 1;
      end
    end
    hs_s_prev = s_hs;
    hs_d_prev = d_hs;
    if (rst_req != rst_seen) begin
      check_bits("reset_outputs_small", rst_snap_s, 6'b0);
      check_bits("reset_outputs_dflt", rst_snap_d, 6'b0);
      rst_seen = rst_req;
    end
    if (done_req && !done_seen) begin
      check_int("start_update_intervals_seen", (intervals >= 4) ? 1 : 0, 1);
      done_seen = 1;
    end
  end

  int tab_px[4] = '{30, 52, 0, 1000};
  int tab_bx[4] = '{10, 60, 0, 1020};
  int tab_by[4] = '{20, 42, 0, 1023};

  initial begin
    rst_n = 1'b0;
    paddle_x = 10'd0; ball_x = 10'd0; ball_y = 10'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int r1, r2;
      r1 = int'($urandom_range(10, 900));
      r2 = int'($urandom_range(1000, 2000));
      repeat (r1) @(negedge clk);
      #2;
      paddle_x = 10'($urandom); ball_x = 10'($urandom); ball_y = 10'($urandom);
      repeat (r2 - r1) @(negedge clk);
      #2;
      if (f < 4) begin
        paddle_x = 10'(tab_px[f]); ball_x = 10'(tab_bx[f]); ball_y = 10'(tab_by[f]);
      end else begin
        paddle_x = 10'($urandom_range(0, 70));
        ball_x   = 10'($urandom_range(0, 70));
        ball_y   = 10'($urandom_range(0, 55));
      end
      if (f == 5) begin
        repeat (1000) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        rst_snap_s = {s_su, s_hs, s_vs, s_r, s_g, s_b};
        rst_snap_d = {d_su, d_hs, d_vs, d_r, d_g, d_b};
        rst_req++;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
      end
      repeat (S_FRAME - r2) @(negedge clk);
    end
    done_req = 1;
    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
